// File: rtl/uart_cmd_sched_pkg.sv
// uart_cmd_sched_pkg: shared types and constants for the UART command scheduler.
//   state_e          - scheduler FSM states
//   DEF_CMD_*        - default ASCII command codes ('r', 'c', 's')
//   ACK_*            - acknowledge bytes sent when CMD_ECHO_EN is defined
//   ASCII_CR         - terminator appended to a status report
//   digit_to_ascii() - BCD digit to ASCII character
package uart_cmd_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StLatch,
      StDecode,
      StTxSend,
      StTxWait
   } state_e;

   localparam logic [7:0] DEF_CMD_RUN  = 8'h72;
   localparam logic [7:0] DEF_CMD_CLR  = 8'h63;
   localparam logic [7:0] DEF_CMD_STAT = 8'h73;

   localparam logic [7:0] ACK_RUN = 8'h52;
   localparam logic [7:0] ACK_CLR = 8'h43;
   localparam logic [7:0] ACK_UNK = 8'h3F;

   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_ZERO = 8'h30;

   localparam logic [13:0] DIGIT_MAX = 14'd9999;

   function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
      return ASCII_ZERO + {4'h0, d};
   endfunction

endpackage

// File: rtl/uart_cmd_sched_bin2ascii4.sv
// bin2ascii4: combinational 14-bit binary to four ASCII decimal digits, MSD in
// ascii[31:24]. Inputs above 9999 saturate to "9999".
//   bin   - binary value (0..16383)
//   ascii - four ASCII characters, most significant digit first
module bin2ascii4
   import uart_cmd_sched_pkg::*;
(
   input  logic [13:0] bin,
   output logic [31:0] ascii
);

   logic [13:0] sat;
   logic [3:0]  d3, d2, d1, d0;

   assign sat = (bin > DIGIT_MAX) ? DIGIT_MAX : bin;

   // Each quotient/remainder is at most 9 once saturated, so 4 bits suffice.
   assign d3 = 4'(sat / 14'd1000);
   assign d2 = 4'((sat / 14'd100) % 14'd10);
   assign d1 = 4'((sat / 14'd10) % 14'd10);
   assign d0 = 4'(sat % 14'd10);

   assign ascii = {digit_to_ascii(d3), digit_to_ascii(d2),
                   digit_to_ascii(d1), digit_to_ascii(d0)};

endmodule

// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched: pops command bytes from an RX FIFO, drives the upcounter
// run/clear controls, merges run/clear button pulses, and sends status reports
// (four ASCII digits + CR) over a UART TX byte handshake.
// Optional build macro: CMD_ECHO_EN - acknowledge 'r', 'c' and unknown bytes
// with 'R', 'C', '?'.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   i_fifo_data/empty   - RX FIFO dout (valid the cycle after the read) / empty
//   o_fifo_rd_en        - RX FIFO read strobe (POP state only)
//   i_btn_run/clr       - debounced button pulses
//   i_digit             - current counter value
//   o_run_on/o_clr_on   - counter run level / clear pulse
//   o_tx_start/data     - UART TX start pulse and byte
//   i_tx_done           - UART TX byte-complete pulse
module uart_cmd_sched
   import uart_cmd_sched_pkg::*;
#(
   parameter logic [7:0] CMD_RUN  = DEF_CMD_RUN,
   parameter logic [7:0] CMD_CLR  = DEF_CMD_CLR,
   parameter logic [7:0] CMD_STAT = DEF_CMD_STAT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  i_fifo_data,
   input  logic        i_fifo_empty,
   output logic        o_fifo_rd_en,
   input  logic        i_btn_run,
   input  logic        i_btn_clr,
   input  logic [13:0] i_digit,
   output logic        o_run_on,
   output logic        o_clr_on,
   output logic        o_tx_start,
   output logic [7:0]  o_tx_data,
   input  logic        i_tx_done
);

   state_e      state_q, state_d;
   logic [7:0]  byte_q, byte_d;
   logic        run_q, run_d;
   logic        clr_q, clr_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [31:0] tx_sr_q, tx_sr_d;     // bytes still to send after tx_data_q
   logic [2:0]  tx_left_q, tx_left_d; // number of valid bytes in tx_sr_q
   logic [31:0] digit_ascii;
   logic        btn_any;

   bin2ascii4 u_bin2ascii4 (
      .bin   (i_digit),
      .ascii (digit_ascii)
   );

   assign btn_any = i_btn_run | i_btn_clr;

   always_comb begin
      state_d      = state_q;
      byte_d       = byte_q;
      run_d        = run_q;
      clr_d        = 1'b0;
      tx_data_d    = tx_data_q;
      tx_sr_d      = tx_sr_q;
      tx_left_d    = tx_left_q;
      o_fifo_rd_en = 1'b0;
      o_tx_start   = 1'b0;

      // Buttons act in every state; clear dominates a coincident run toggle.
      if (i_btn_clr) begin
         run_d = 1'b0;
         clr_d = 1'b1;
      end else if (i_btn_run) begin
         run_d = ~run_q;
      end

      case (state_q)
         StIdle: begin
            if (!i_fifo_empty) state_d = StPop;
         end
         StPop: begin
            // Empty cannot rise here without a read, but never strobe an empty FIFO.
            if (!i_fifo_empty) begin
               o_fifo_rd_en = 1'b1;
               state_d      = StLatch;
            end else begin
               state_d = StIdle;
            end
         end
         StLatch: begin
            byte_d  = i_fifo_data;
            state_d = StDecode;
         end
         StDecode: begin
            // A button pulse owns this cycle; the command is applied next cycle.
            if (!btn_any) begin
               if (byte_q == CMD_STAT) begin
                  tx_data_d = digit_ascii[31:24];
                  tx_sr_d   = {digit_ascii[23:0], ASCII_CR};
                  tx_left_d = 3'd4;
                  state_d   = StTxSend;
               end else begin
                  if (byte_q == CMD_RUN) begin
                     run_d = ~run_q;
                  end else if (byte_q == CMD_CLR) begin
                     run_d = 1'b0;
                     clr_d = 1'b1;
                  end
`ifdef CMD_ECHO_EN
                  if (byte_q == CMD_RUN)      tx_data_d = ACK_RUN;
                  else if (byte_q == CMD_CLR) tx_data_d = ACK_CLR;
                  else                        tx_data_d = ACK_UNK;
                  tx_left_d = 3'd0;
                  state_d   = StTxSend;
`else
                  state_d = StIdle;
`endif
               end
            end
         end
         StTxSend: begin
            o_tx_start = 1'b1;
            state_d    = StTxWait;
         end
         StTxWait: begin
            if (i_tx_done) begin
               if (tx_left_q != 3'd0) begin
                  tx_data_d = tx_sr_q[31:24];
                  tx_sr_d   = {tx_sr_q[23:0], 8'h00};
                  tx_left_d = tx_left_q - 3'd1;
                  state_d   = StTxSend;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         byte_q    <= 8'h00;
         run_q     <= 1'b0;
         clr_q     <= 1'b0;
         tx_data_q <= 8'h00;
         tx_sr_q   <= 32'h0;
         tx_left_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         byte_q    <= byte_d;
         run_q     <= run_d;
         clr_q     <= clr_d;
         tx_data_q <= tx_data_d;
         tx_sr_q   <= tx_sr_d;
         tx_left_q <= tx_left_d;
      end
   end

   assign o_run_on  = run_q;
   assign o_clr_on  = clr_q;
   assign o_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// tb_uart_cmd_sched: directed self-checking bench for uart_cmd_sched. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_uart_cmd_sched;
   import uart_cmd_sched_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  fifo_data = 8'h00;
   logic        fifo_empty = 1'b1;
   logic        btn_run = 1'b0;
   logic        btn_clr = 1'b0;
   logic [13:0] digit = 14'd0;
   logic        tx_done = 1'b0;
   logic        fifo_rd_en, run_on, clr_on, tx_start;
   logic [7:0]  tx_data;

   int n_checks = 0;
   int n_pass = 0;
   int rd_during_tx = 0;

   uart_cmd_sched dut (
      .clk          (clk),
      .reset        (reset),
      .i_fifo_data  (fifo_data),
      .i_fifo_empty (fifo_empty),
      .o_fifo_rd_en (fifo_rd_en),
      .i_btn_run    (btn_run),
      .i_btn_clr    (btn_clr),
      .i_digit      (digit),
      .o_run_on     (run_on),
      .o_clr_on     (clr_on),
      .o_tx_start   (tx_start),
      .o_tx_data    (tx_data),
      .i_tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Present one byte; returns at the falling edge where the FSM is in LATCH.
   task automatic feed(input logic [7:0] b);
      @(negedge clk);
      fifo_empty = 1'b0;
      @(negedge clk);
      check("pop_strobe", 32'(fifo_rd_en), 32'd1);
      @(negedge clk);
      fifo_empty = 1'b1;
      fifo_data  = b;
      check("pop_single", 32'(fifo_rd_en), 32'd0);
   endtask

   task automatic wait_start(output logic got);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (tx_start) begin
            got = 1'b1;
            break;
         end
         if (fifo_rd_en) rd_during_tx++;
         @(negedge clk);
      end
   endtask

   task automatic serve_tx(input logic [7:0] exp, input string tag);
      logic got;
      int   early;
      early = 0;
      wait_start(got);
      check({tag, "_start"}, 32'(got), 32'd1);
      check({tag, "_data"}, 32'(tx_data), 32'(exp));
      repeat (3) begin
         @(negedge clk);
         if (tx_start) early++;
         if (fifo_rd_en) rd_during_tx++;
      end
      check({tag, "_hold"}, 32'(tx_data), 32'(exp));
      check({tag, "_start_before_done"}, early, 0);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic expect_echo(input logic [7:0] ack);
`ifdef CMD_ECHO_EN
      serve_tx(ack, "echo");
`else
      begin
         int seen;
         seen = 0;
         repeat (6) begin
            if (tx_start) seen++;
            @(negedge clk);
         end
         check($sformatf("no_echo_%0h", ack), seen, 0);
      end
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
      check({tag, "_run"}, 32'(run_on), 32'd0);
      check({tag, "_clr"}, 32'(clr_on), 32'd0);
      check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
   endtask

   initial begin
      logic got;
      int   starts;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      // 'r': single pop strobe, run toggles after POP, LATCH, DECODE
      feed(8'h72);
      @(negedge clk);
      check("run_latency", 32'(run_on), 32'd0);
      @(negedge clk);
      check("run_toggle", 32'(run_on), 32'd1);
      expect_echo(ACK_RUN);

      // 's' with 1234
      digit = 14'd1234;
      feed(8'h73);
      @(negedge clk);
      @(negedge clk);
      serve_tx(8'h31, "stat1234_0");
      serve_tx(8'h32, "stat1234_1");
      serve_tx(8'h33, "stat1234_2");
      serve_tx(8'h34, "stat1234_3");
      serve_tx(8'h0D, "stat1234_cr");
      starts = 0;
      repeat (6) begin
         if (tx_start) starts++;
         @(negedge clk);
      end
      check("stat1234_no_extra", starts, 0);
      check("stat_keeps_run", 32'(run_on), 32'd1);

      // 's' with 12000 saturates; a byte waiting in the FIFO is not read mid-report
      digit = 14'd12000;
      feed(8'h73);
      @(negedge clk);
      @(negedge clk);
      fifo_empty   = 1'b0;
      rd_during_tx = 0;
      serve_tx(8'h39, "sat_0");
      serve_tx(8'h39, "sat_1");
      serve_tx(8'h39, "sat_2");
      serve_tx(8'h39, "sat_3");
      serve_tx(8'h0D, "sat_cr");
      check("no_pop_during_tx", rd_during_tx, 0);
      @(negedge clk);
      check("pop_after_tx", 32'(fifo_rd_en), 32'd1);
      @(negedge clk);
      fifo_empty = 1'b1;
      fifo_data  = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check("unknown_keeps_run", 32'(run_on), 32'd1);
      expect_echo(ACK_UNK);

      // Run and clear buttons together: clear wins, single pulse
      @(negedge clk);
      btn_run = 1'b1;
      btn_clr = 1'b1;
      @(negedge clk);
      btn_run = 1'b0;
      btn_clr = 1'b0;
      check("both_btn_run", 32'(run_on), 32'd0);
      check("both_btn_clr", 32'(clr_on), 32'd1);
      @(negedge clk);
      check("both_btn_clr_once", 32'(clr_on), 32'd0);

      // Run button alone
      btn_run = 1'b1;
      @(negedge clk);
      btn_run = 1'b0;
      check("btn_run_toggle", 32'(run_on), 32'd1);

      // 'c': clear pulse, run forced off
      feed(8'h63);
      @(negedge clk);
      check("clr_latency", 32'(clr_on), 32'd0);
      @(negedge clk);
      check("clr_pulse", 32'(clr_on), 32'd1);
      check("clr_stops_run", 32'(run_on), 32'd0);
      expect_echo(ACK_CLR);

      // Unknown byte 'A'
      feed(8'h41);
      @(negedge clk);
      @(negedge clk);
      check("unk_run", 32'(run_on), 32'd0);
      check("unk_clr", 32'(clr_on), 32'd0);
      expect_echo(ACK_UNK);

      // Button coinciding with DECODE of 'r': button first, command one cycle later
      feed(8'h72);
      @(negedge clk);
      btn_run = 1'b1;
      @(negedge clk);
      btn_run = 1'b0;
      check("btn_in_decode", 32'(run_on), 32'd1);
      @(negedge clk);
      check("decode_after_btn", 32'(run_on), 32'd0);
      expect_echo(ACK_RUN);

      // Reset in the middle of a status report
      btn_run = 1'b1;
      @(negedge clk);
      btn_run = 1'b0;
      check("pre_reset_run", 32'(run_on), 32'd1);
      digit = 14'd1234;
      feed(8'h73);
      @(negedge clk);
      @(negedge clk);
      serve_tx(8'h31, "mid_0");
      wait_start(got);
      check("mid_1_start", 32'(got), 32'd1);
      check("mid_1_data", 32'(tx_data), 32'h32);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("mid_reset");
      starts = 0;
      repeat (10) begin
         @(negedge clk);
         if (tx_start) starts++;
      end
      check("abandoned_bytes", starts, 0);
      feed(8'h72);
      @(negedge clk);
      @(negedge clk);
      check("post_reset_run", 32'(run_on), 32'd1);
      expect_echo(ACK_RUN);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
